// File: rtl/control_heroe.sv
// Hero controller: input synchronizers, jump FSM, lives and collision/bonus evaluation on obstacle ticks.
// Optional double jump in the air is enabled by defining SALTO_DOBLE_EN.
module control_heroe #(
  parameter logic [2:0]  OFF         = 3'd0,
  parameter logic [2:0]  GAME        = 3'd3,
  parameter logic [2:0]  WL          = 3'd4,
  parameter int unsigned SALTO_TICKS = 2,
  parameter int unsigned VIDAS_INI   = 3,
  parameter logic [4:0]  TIPO_BONO   = 5'd16,
  parameter logic [6:0]  SEG_SUELO   = 7'b0001000,
  parameter logic [6:0]  SEG_AIRE    = 7'b0000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  presente,
  input  logic        clk_obstaculos,
  input  logic        boton_salto,
  input  logic [20:0] display_obs,
  input  logic [4:0]  tipo_obs,
  input  logic [1:0]  mundo,
  output logic        bono_tomado,
  output logic [1:0]  W_or_L,
  output logic [1:0]  vidas,
  output logic [6:0]  display_heroe
);

  localparam int unsigned AW = 3;
  localparam logic [1:0] T_VACIO  = 2'd0;
  localparam logic [1:0] T_SUELO  = 2'd1;
  localparam logic [1:0] T_AIRE   = 2'd2;
  localparam logic [1:0] T_BONO   = 2'd3;

  typedef enum logic [2:0] {INACTIVO, SUELO, AIRE, PERDIO, GANO} state_t;

  state_t           state, state_d;
  logic [2:0]       obs_sync, btn_sync;
  logic             eval;
  logic [2:0][1:0]  tp, tp_d;
  logic [AW-1:0]    air, air_d;
  logic [1:0]       vidas_d, wl_d;
  logic             bono_d;
  logic [6:0]       glyph_d;
  logic [1:0]       tp_new, item;
  logic             tick, salto, hit, win, presente_ok;
`ifdef SALTO_DOBLE_EN
  logic             dbl_used, dbl_d;
`endif

  assign tick        = obs_sync[1] & ~obs_sync[2];
  assign salto       = btn_sync[1] & ~btn_sync[2];
  assign presente_ok = (presente == GAME) || (presente == WL);
  assign item        = tp[1];

  // Classify the item entering the field this eval
  always_comb begin
    tp_new = T_VACIO;
    if (tipo_obs == TIPO_BONO)        tp_new = T_BONO;
    else if (display_obs[20:14] != '0) tp_new = tipo_obs[0] ? T_AIRE : T_SUELO;
  end

  assign hit = eval && (((item == T_SUELO) && (state == SUELO)) ||
                        ((item == T_AIRE)  && (state == AIRE)));

  always_comb begin
    state_d = state;
    vidas_d = vidas;
    tp_d    = tp;
    air_d   = air;
    bono_d  = 1'b0;
    wl_d    = W_or_L;
    win     = 1'b0;
`ifdef SALTO_DOBLE_EN
    dbl_d   = dbl_used;
`endif
    case (state)
      INACTIVO: begin
        if (presente == GAME) begin
          state_d = SUELO;
          vidas_d = 2'(VIDAS_INI);
          tp_d    = '0;
          wl_d    = 2'b00;
        end
      end
      SUELO, AIRE: begin
        if (eval) begin
          tp_d = {tp_new, tp[2], tp[1]};
          if ((item == T_BONO) && (state == AIRE)) bono_d = 1'b1;
          if (hit) vidas_d = vidas - 2'd1;
          win = (mundo == 2'd3) && (tp_d == '0) && (display_obs == '0);
        end
        // A fatal hit outranks a simultaneous win
        if (hit && (vidas == 2'd1)) begin
          state_d = PERDIO;
          wl_d    = 2'b01;
          air_d   = '0;
        end else if (win) begin
          state_d = GANO;
          wl_d    = 2'b10;
          air_d   = '0;
        end else if (state == SUELO) begin
          if (salto) begin
            state_d = AIRE;
            air_d   = AW'(SALTO_TICKS);
`ifdef SALTO_DOBLE_EN
            dbl_d   = 1'b0;
`endif
          end
        end else begin
`ifdef SALTO_DOBLE_EN
          if (salto && !dbl_used) begin
            air_d = AW'(SALTO_TICKS);
            dbl_d = 1'b1;
          end else
`endif
          if (eval) begin
            air_d = air - AW'(1);
            if (air == AW'(1)) state_d = SUELO;
          end
        end
      end
      PERDIO, GANO: ;
      default: state_d = INACTIVO;
    endcase
    if (!presente_ok) begin
      state_d = INACTIVO;
      air_d   = '0;
      wl_d    = 2'b00;
      bono_d  = 1'b0;
    end
  end

  always_comb begin
    glyph_d = 7'b0;
    case (state_d)
      SUELO, PERDIO: glyph_d = SEG_SUELO;
      AIRE, GANO:    glyph_d = SEG_AIRE;
      default:       glyph_d = 7'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INACTIVO;
      obs_sync      <= '0;
      btn_sync      <= '0;
      eval          <= 1'b0;
      tp            <= '0;
      air           <= '0;
      vidas         <= 2'(VIDAS_INI);
      W_or_L        <= 2'b00;
      bono_tomado   <= 1'b0;
      display_heroe <= 7'b0;
`ifdef SALTO_DOBLE_EN
      dbl_used      <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      obs_sync      <= {obs_sync[1:0], clk_obstaculos};
      btn_sync      <= {btn_sync[1:0], boton_salto};
      eval          <= tick;
      tp            <= tp_d;
      air           <= air_d;
      vidas         <= vidas_d;
      W_or_L        <= wl_d;
      bono_tomado   <= bono_d;
      display_heroe <= glyph_d;
`ifdef SALTO_DOBLE_EN
      dbl_used      <= dbl_d;
`endif
    end
  end

endmodule
